// File: rtl/vscale_lsu_sb.sv
// Load/store unit with an in-order store buffer draining to the data port.
// Loads bypass the buffer and stall while any buffered entry hits their word.
module vscale_lsu_sb #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_misaligned,
    output logic              sb_empty,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wstrb,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);
    localparam int NB  = XLEN / 8;
    localparam int OFF = $clog2(NB);
    localparam int PW  = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LREQ,
        S_LWAIT
    } ld_state_t;

    ld_state_t         r_state;
    ld_state_t         w_state_nx;

    logic [ADDR_W-1:0] r_faddr [DEPTH];
    logic [XLEN-1:0]   r_fdata [DEPTH];
    logic [NB-1:0]     r_fstrb [DEPTH];
    logic [DEPTH-1:0]  r_fvld;
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [PW:0]       r_count;
    logic              r_spend;

    logic [ADDR_W-1:0] r_laddr;
    logic [1:0]        r_lsize;
    logic              r_luns;

    logic              r_resp_valid;
    logic [XLEN-1:0]   r_resp_rdata;
    logic              r_resp_mis;

    logic [ADDR_W-1:0] w_waddr;
    logic [OFF-1:0]    w_off;
    logic [2:0]        w_amask;
    logic              w_mis;
    logic              w_hazard;
    logic              w_full;
    logic              w_ready;
    logic              w_acc;
    logic              w_acc_mis;
    logic              w_push;
    logic              w_acc_ld;
    logic              w_ld_own;
    logic              w_st_own;
    logic              w_pop;
    logic              w_cap;
    logic [XLEN-1:0]   w_rep;
    logic [NB-1:0]     w_smask;
    logic [NB-1:0]     w_strb;
    logic [XLEN-1:0]   w_lsh;
    logic              w_sext;
    logic [XLEN-1:0]   w_ldata;

    assign w_waddr = {req_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
    assign w_off   = req_addr[OFF-1:0];

    always_comb begin
        w_amask = 3'b111;
        unique case (req_size)
            2'd0:    w_amask = 3'b000;
            2'd1:    w_amask = 3'b001;
            2'd2:    w_amask = 3'b011;
            default: w_amask = 3'b111;
        endcase
        w_mis = (|(req_addr[2:0] & w_amask)) ||
                (req_size == 2'd3 && XLEN < 64);
    end

    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_fvld[i] && r_faddr[i] == w_waddr)
                w_hazard = 1'b1;
        end
    end

    always_comb begin
        w_rep   = '0;
        w_smask = '0;
        for (int i = 0; i < NB; i++) begin
            case (req_size)
                2'd0:    w_rep[8*i +: 8] = req_wdata[7:0];
                2'd1:    w_rep[8*i +: 8] = req_wdata[8*(i%2) +: 8];
                2'd2:    w_rep[8*i +: 8] = req_wdata[8*(i%4) +: 8];
                default: w_rep[8*i +: 8] = req_wdata[8*(i%8) +: 8];
            endcase
            w_smask[i] = (32'(i) < (32'd1 << req_size));
        end
        w_strb = w_smask << w_off;
    end

    assign w_full    = (r_count == (PW+1)'(DEPTH));
    assign w_ready   = reset_n && (r_state == S_IDLE) &&
                       (w_mis || (req_wen ? !w_full : !w_hazard));
    assign w_acc     = req_valid && w_ready;
    assign w_acc_mis = w_acc && w_mis;
    assign w_push    = w_acc && !w_mis && req_wen;
    assign w_acc_ld  = w_acc && !w_mis && !req_wen;

    // A store already shown on the port keeps it until accepted.
    assign w_ld_own = (r_state == S_LREQ) && !r_spend;
    assign w_st_own = r_spend || (!w_ld_own && r_count != '0);
    assign w_pop    = w_st_own && mem_ready;
    assign w_cap    = (w_ld_own && mem_ready && mem_rvalid) ||
                      (r_state == S_LWAIT && mem_rvalid);

    always_comb begin
        mem_valid = w_ld_own || w_st_own;
        mem_wen   = w_st_own;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (w_st_own) begin
            mem_addr  = r_faddr[r_head];
            mem_wdata = r_fdata[r_head];
            mem_wstrb = r_fstrb[r_head];
        end else if (w_ld_own) begin
            mem_addr = {r_laddr[ADDR_W-1:OFF], {OFF{1'b0}}};
        end
    end

    always_comb begin
        w_lsh  = mem_rdata >> {r_laddr[OFF-1:0], 3'b000};
        w_sext = 1'b0;
        unique case (r_lsize)
            2'd0:    w_sext = w_lsh[7];
            2'd1:    w_sext = w_lsh[15];
            2'd2:    w_sext = w_lsh[31];
            default: w_sext = w_lsh[(XLEN >= 64) ? 63 : XLEN-1];
        endcase
        w_sext  = w_sext && !r_luns;
        w_ldata = '0;
        for (int j = 0; j < XLEN; j++) begin
            w_ldata[j] = (32'(j) < (32'd8 << r_lsize)) ? w_lsh[j] : w_sext;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE:  if (w_acc_ld) w_state_nx = S_LREQ;
            S_LREQ:  if (w_ld_own && mem_ready)
                         w_state_nx = mem_rvalid ? S_IDLE : S_LWAIT;
            S_LWAIT: if (mem_rvalid) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_fvld  <= '0;
            r_spend <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_faddr[i] <= '0;
                r_fdata[i] <= '0;
                r_fstrb[i] <= '0;
            end
        end else begin
            r_spend <= w_st_own && !mem_ready;
            if (w_pop) begin
                r_fvld[r_head] <= 1'b0;
                r_head         <= r_head + PW'(1);
            end
            if (w_push) begin
                r_faddr[r_tail] <= w_waddr;
                r_fdata[r_tail] <= w_rep;
                r_fstrb[r_tail] <= w_strb;
                r_fvld[r_tail]  <= 1'b1;
                r_tail          <= r_tail + PW'(1);
            end
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_laddr      <= '0;
            r_lsize      <= '0;
            r_luns       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_mis   <= 1'b0;
        end else begin
            if (w_acc_ld) begin
                r_laddr <= req_addr;
                r_lsize <= req_size;
                r_luns  <= req_unsigned;
            end
            r_resp_valid <= w_acc_mis || w_push || w_cap;
            r_resp_rdata <= w_cap ? w_ldata : '0;
            r_resp_mis   <= w_acc_mis;
        end
    end

    assign req_ready       = w_ready;
    assign resp_valid      = r_resp_valid;
    assign resp_rdata      = r_resp_rdata;
    assign resp_misaligned = r_resp_mis;
    assign sb_empty        = (r_count == '0) && !(mem_valid && mem_wen);

endmodule

// File: tb/tb_vscale_lsu_sb.sv
// Scoreboard bench: byte-array reference memory predicts every response
// and every memory write; a responder models the data port.
module tb_vscale_lsu_sb;
    localparam int XLEN  = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_wen = 1'b0;
    logic [1:0]      req_size = 2'd2;
    logic            req_unsigned = 1'b0;
    logic [AW-1:0]   req_addr = '0;
    logic [XLEN-1:0] req_wdata = '0;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_misaligned;
    logic            sb_empty;
    logic            mem_valid;
    logic            mem_ready = 1'b0;
    logic            mem_wen;
    logic [AW-1:0]   mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_wstrb;
    logic            mem_rvalid = 1'b0;
    logic [XLEN-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    vscale_lsu_sb #(.XLEN(XLEN), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_wen(req_wen), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_misaligned(resp_misaligned), .sb_empty(sb_empty),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        bit          mis;
        bit          ld;
        logic [31:0] rdata;
        int          t;
    } exp_t;
    typedef struct {
        logic [31:0] addr;
        int          n;
        logic [31:0] data;
    } wr_t;

    exp_t        exp_q[$];
    wr_t         wq[$];
    logic [7:0]  pmem [1024];
    logic [7:0]  rmem [1024];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          wr_cnt = 0;
    int          resp_cnt = 0;
    int          mv_cnt = 0;
    logic [31:0] last_rdata = '0;
    logic        last_mis = 1'b0;
    bit          hold = 1'b0;
    bit          no_rv = 1'b0;
    bit          pend = 1'b0;
    logic [31:0] paddr = '0;
    bit          st_pend = 1'b0;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_strb;
    logic        s_wen;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] rd_word(logic [31:0] a);
        int b;
        b = int'(a[9:0]) & ~3;
        return {pmem[b+3], pmem[b+2], pmem[b+1], pmem[b]};
    endfunction

    // Memory side and request acceptance, sampled at the active edge.
    always @(posedge clk) begin
        exp_t        e;
        wr_t         w;
        int          n, off, a;
        logic [31:0] v, es, ed, bm;
        if (!reset_n) begin
            st_pend = 1'b0;
        end else begin
            if (st_pend) begin
                chk("hold_valid", {31'd0, mem_valid}, 32'd1);
                chk("hold_addr", mem_addr, s_addr);
                chk("hold_wdata", mem_wdata, s_wdata);
                chk("hold_wstrb", {28'd0, mem_wstrb}, {28'd0, s_strb});
                chk("hold_wen", {31'd0, mem_wen}, {31'd0, s_wen});
            end
            st_pend = mem_valid && !mem_ready;
            s_addr = mem_addr; s_wdata = mem_wdata;
            s_strb = mem_wstrb; s_wen = mem_wen;
            if (mem_valid) mv_cnt++;
            if (pend && mem_rvalid) pend = 1'b0;
            if (mem_valid && mem_ready) begin
                if (mem_wen) begin
                    wr_cnt++;
                    if (wq.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_write: addr %h", mem_addr);
                    end else begin
                        w = wq.pop_front();
                        off = int'(w.addr[1:0]);
                        es = '0; ed = '0; bm = '0;
                        for (int k = 0; k < w.n; k++) begin
                            es[off+k] = 1'b1;
                            ed[8*(off+k) +: 8] = w.data[8*k +: 8];
                        end
                        for (int b = 0; b < 4; b++)
                            if (mem_wstrb[b]) bm[8*b +: 8] = 8'hFF;
                        chk("wr_addr", mem_addr, {w.addr[31:2], 2'b00});
                        chk("wr_strb", {28'd0, mem_wstrb}, es);
                        chk("wr_data", mem_wdata & bm, ed);
                    end
                    for (int b = 0; b < 4; b++)
                        if (mem_wstrb[b])
                            pmem[int'(mem_addr[9:0]) + b] = mem_wdata[8*b +: 8];
                end else if (!mem_rvalid) begin
                    pend = 1'b1;
                    paddr = mem_addr;
                end
            end
            if (req_valid && req_ready) begin
                n = 1 << req_size;
                a = int'(req_addr[9:0]);
                e.mis = (req_size == 2'd3) || ((a % n) != 0);
                e.ld = !req_wen && !e.mis;
                e.rdata = '0;
                e.t = cyc;
                if (!e.mis && req_wen) begin
                    for (int k = 0; k < n; k++)
                        rmem[(a+k) % 1024] = req_wdata[8*k +: 8];
                    w.addr = req_addr; w.n = n; w.data = req_wdata;
                    wq.push_back(w);
                end else if (e.ld) begin
                    v = '0;
                    for (int k = 0; k < n; k++) v[8*k +: 8] = rmem[(a+k) % 1024];
                    if (!req_unsigned && n < 4 && v[8*n-1])
                        for (int k = 8*n; k < 32; k++) v[k] = 1'b1;
                    e.rdata = v;
                end
                exp_q.push_back(e);
                acc_cnt++;
            end
        end
        cyc++;
    end

    // Response monitor.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && resp_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_resp: rdata %h", resp_rdata);
            end else begin
                e = exp_q.pop_front();
                chk("resp_mis", {31'd0, resp_misaligned}, {31'd0, e.mis});
                chk("resp_rdata", resp_rdata, e.rdata);
                if (e.ld) chk("ld_latency_ge2", {31'd0, (cyc - e.t) >= 2}, 32'd1);
                else      chk("st_latency", cyc - e.t, 32'd1);
            end
            last_rdata = resp_rdata;
            last_mis = resp_misaligned;
            resp_cnt++;
        end
    end

    // Data-port responder.
    always @(negedge clk) begin
        mem_ready = !hold && ($urandom_range(0, 3) != 0);
        mem_rvalid = 1'b0;
        mem_rdata = $urandom;
        if (!no_rv) begin
            if (pend) begin
                if ($urandom_range(0, 2) != 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = rd_word(paddr);
                end
            end else if (reset_n && mem_valid && !mem_wen && mem_ready &&
                         $urandom_range(0, 1) == 1) begin
                mem_rvalid = 1'b1;
                mem_rdata = rd_word(mem_addr);
            end
        end
    end

    task automatic wait_acc(input int a0, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (acc_cnt != a0) begin
                ok = 1'b1;
                break;
            end
        end
        req_valid = 1'b0;
        if (!ok) chk(nm, 32'd0, 32'd1);
    endtask

    task automatic do_req(input logic wen, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a,
                          input logic [31:0] d);
        req_wen = wen; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = d; req_valid = 1'b1;
        wait_acc(acc_cnt, "accept_timeout");
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (exp_q.size() == 0 && sb_empty && !pend) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic flush_model();
        exp_q.delete();
        wq.delete();
        pend = 1'b0;
        for (int i = 0; i < 1024; i++) rmem[i] = pmem[i];
    endtask

    initial begin
        int a0, w0, m0;
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, w0, m0;
        for (int i = 0; i < 1024; i++) begin
            pmem[i] = 8'($urandom);
            rmem[i] = pmem[i];
        end
        req_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_mis", {31'd0, resp_misaligned}, 32'd0);
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
        chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("rst_sb_empty", {31'd0, sb_empty}, 32'd1);
        req_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);

        {pmem[256], pmem[257], pmem[258], pmem[259]} = 32'h01_7F_FF_80;
        for (int i = 256; i < 260; i++) rmem[i] = pmem[i];
        do_req(1'b0, 2'd1, 1'b0, 32'h102, '0); wait_drain();
        chk("lh_signed", last_rdata, 32'hFFFF80FF);
        do_req(1'b0, 2'd1, 1'b1, 32'h102, '0); wait_drain();
        chk("lhu", last_rdata, 32'h000080FF);
        do_req(1'b0, 2'd0, 1'b0, 32'h101, '0); wait_drain();
        chk("lb", last_rdata, 32'h0000007F);

        hold = 1'b1;
        do_req(1'b1, 2'd0, 1'b0, 32'h103, 32'h123456AB);
        chk("sb_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("sb_mem_valid", {31'd0, mem_valid}, 32'd1);
        chk("sb_mem_addr", mem_addr, 32'h100);
        chk("sb_mem_wdata", mem_wdata, 32'hABABABAB);
        chk("sb_mem_wstrb", {28'd0, mem_wstrb}, 32'h8);
        chk("sb_not_empty", {31'd0, sb_empty}, 32'd0);
        hold = 1'b0;
        wait_drain();
        chk("sb_empty_after", {31'd0, sb_empty}, 32'd1);

        m0 = mv_cnt;
        do_req(1'b0, 2'd2, 1'b0, 32'h202, '0); wait_drain();
        chk("lw_mis_flag", {31'd0, last_mis}, 32'd1);
        do_req(1'b1, 2'd1, 1'b0, 32'h201, 32'hBEEF); wait_drain();
        chk("sh_mis_flag", {31'd0, last_mis}, 32'd1);
        chk("mis_no_mem", mv_cnt - m0, 32'd0);

        hold = 1'b1;
        for (int i = 0; i < 4; i++)
            do_req(1'b1, 2'd2, 1'b0, 32'h20 + 32'(4*i), $urandom);
        req_wen = 1'b1; req_size = 2'd2; req_addr = 32'h30;
        req_wdata = $urandom; req_valid = 1'b1;
        a0 = acc_cnt;
        repeat (3) @(negedge clk);
        chk("full_ready", {31'd0, req_ready}, 32'd0);
        chk("full_no_accept", acc_cnt - a0, 32'd0);
        w0 = wr_cnt;
        hold = 1'b0;
        wait_acc(a0, "full_accept_timeout");
        chk("full_drain_first", {31'd0, wr_cnt > w0}, 32'd1);
        wait_drain();

        hold = 1'b1;
        do_req(1'b1, 2'd2, 1'b0, 32'h300, 32'h12345678);
        req_wen = 1'b0; req_size = 2'd2; req_addr = 32'h300;
        req_valid = 1'b1;
        a0 = acc_cnt;
        repeat (3) @(negedge clk);
        chk("haz_ready", {31'd0, req_ready}, 32'd0);
        hold = 1'b0;
        wait_acc(a0, "haz_accept_timeout");
        wait_drain();
        chk("haz_data", last_rdata, 32'h12345678);

        for (int i = 0; i < 400; i++) begin
            do_req(1'($urandom), 2'($urandom), 1'($urandom),
                   32'($urandom_range(0, 63)), $urandom);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        wait_drain();

        no_rv = 1'b1;
        do_req(1'b0, 2'd2, 1'b0, 32'h10, '0);
        for (int i = 0; i < 100 && !pend; i++) @(negedge clk);
        chk("lwait_reached", {31'd0, pend}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_lwait_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_lwait_resp_valid", {31'd0, resp_valid}, 32'd0);
        flush_model();
        no_rv = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post_rst_sb_empty", {31'd0, sb_empty}, 32'd1);
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);

        hold = 1'b1;
        do_req(1'b1, 2'd2, 1'b0, 32'h14, 32'hCAFEF00D);
        @(negedge clk);
        chk("pre_rst_mem_valid", {31'd0, mem_valid}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_store_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_store_sb_empty", {31'd0, sb_empty}, 32'd1);
        flush_model();
        hold = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_req(1'b0, 2'd2, 1'b0, 32'h14, '0);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
